// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared definitions for the BCD blocks. It holds the digit
//                width, the double-dabble correction constants, the converter
//                FSM state type, and a helper that returns the number of
//                decimal digits needed to represent any BIN_W-bit value.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // Number of decimal digits in 2**bin_w - 1. The result is at least 1.
    function automatic int bcd_digits_for(input int bin_w);
        longint unsigned v;
        int              n;
        v = (64'd1 << bin_w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                n = n + 1;
                v = v / 64'd10;
            end
        end
        return (n == 0) ? 1 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_dabble_digit
//  Description : Combinational double-dabble correction for one BCD digit.
//                Adds 3 when the digit is 5 or more, so that the following
//                left shift carries correctly into the next decimal digit.
//  Ports       : digit_in  [3:0] - BCD digit before correction
//                digit_out [3:0] - corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_dabble_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_ADJ_THRESH) begin
            digit_out = digit_in + BCD_ADJ;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Iterative binary-to-BCD converter that uses the shift-and-
//                add-3 (double dabble) method. It performs one iteration per
//                clock and has valid/ready handshakes on the input and output.
//  Macro       : BIN2BCD_SIGNED_EN - when defined, bin_in is two's complement.
//                The magnitude is converted and sign_out reports the sign.
//  Ports       : clk, rst                - clock, synchronous active-high reset
//                in_valid/in_ready       - input handshake
//                bin_in    [BIN_W-1:0]   - binary operand
//                out_valid/out_ready     - output handshake
//                bcd_out   [4*DIGITS-1:0]- packed BCD, units digit in [3:0]
//                overflow                - value exceeds 10**DIGITS-1
//                sign_out                - sign of operand (signed build only)
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                          sign_out
`endif
);

    localparam int c_CNT_W = $clog2(BIN_W + 1);
    localparam int c_BCD_W = BCD_DIGIT_W * DIGITS;
    // If DIGITS covers every BIN_W-bit value, the overflow logic is constant 0.
    localparam bit c_CAN_OVF = (DIGITS < bcd_digits_for(BIN_W));

    bcd_state_t         r_state;
    bcd_state_t         w_state_nxt;
    logic [BIN_W-1:0]   r_shreg;
    logic [c_BCD_W-1:0] r_digits;
    logic [c_BCD_W-1:0] w_adj;
    logic               r_ovf;
    logic [c_CNT_W-1:0] r_cnt;
    logic [BIN_W-1:0]   w_load;

`ifdef BIN2BCD_SIGNED_EN
    logic r_sign;

    // The largest magnitude, 2**(BIN_W-1), still fits in BIN_W unsigned bits.
    // Negating in BIN_W bits therefore gives the exact magnitude, including
    // for the most negative input.
    always_comb begin
        w_load = bin_in;
        if (bin_in[BIN_W-1]) begin
            w_load = ~bin_in + BIN_W'(1);
        end
    end

    assign sign_out = r_sign;
`else
    assign w_load = bin_in;
`endif

    // One add-3 correction per digit, applied before each shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_dabble_digit u_digit (
            .digit_in  (r_digits[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // The counter reaches zero after BIN_W shifts. The cycle that
                // sees zero then moves to DONE.
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg  <= '0;
            r_digits <= '0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
`ifdef BIN2BCD_SIGNED_EN
            r_sign   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shreg  <= w_load;
                        r_digits <= '0;
                        r_ovf    <= 1'b0;
                        r_cnt    <= c_CNT_W'(BIN_W);
`ifdef BIN2BCD_SIGNED_EN
                        r_sign   <= bin_in[BIN_W-1];
`endif
                    end
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        // Shift {corrected digits, shreg} left by one. The bit
                        // that leaves the top digit is lost and marks overflow.
                        r_digits <= {w_adj[c_BCD_W-2:0], r_shreg[BIN_W-1]};
                        r_shreg  <= r_shreg << 1;
                        r_ovf    <= r_ovf | (c_CAN_OVF & w_adj[c_BCD_W-1]);
                        r_cnt    <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_out  = r_digits;
    assign overflow = r_ovf;

endmodule
`default_nettype wire
